prio_enc_queue: RTL and testbench

- Parametrised, registered successor to the team's combinational 8-to-3 priority encoder with enable.
- Latches pulsed request lines into a sticky pending vector.
- Emits one encoded index per grant over a valid/ready handshake, highest index first, and clears each granted bit.
- Sits between interrupt/event sources and a single consumer that services one index at a time.

---
 rtl/prio_enc_queue.sv | 142 ++++++++++++++
 tb/tb_prio_enc_queue.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prio_enc_queue.sv
// prio_enc_queue: registered priority encoder queue.
//
// Pulsed request lines are latched into a sticky pending vector. A valid/ready
// port then emits one encoded index per grant and clears that pending bit.
// The default build grants the highest pending index first.
//
// Optional feature: define PRIENC_RR_EN to get rotating priority. The search
// then begins just below the last granted index and wraps from 0 to N-1.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   enable     gates request latching and new grant loads
//   req[N]     request pulses, bit k = source k
//   out_valid  out_idx holds a granted index
//   out_ready  consumer accepts out_idx when out_valid && out_ready
//   out_idx    encoded granted index (IDX_W bits)
//   pending[N] registered pending vector (not yet granted)
//   overflow   one-cycle pulse: request hit an already pending bit
module prio_enc_queue #(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [N-1:0]     req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [N-1:0]     pending,
  output logic             overflow
);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     pending_q, pending_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic             overflow_q, overflow_d;
  logic [N-1:0]     clr;
  logic [IDX_W-1:0] sel;
  logic             load;

`ifdef PRIENC_RR_EN
  // Index where the next search begins. Holding "last grant - 1" rather than
  // the last grant itself makes the reset value N-1 start the search at N-1.
  logic [IDX_W-1:0] start_q, start_d;
  int unsigned      rr_idx;
  logic             found;

  always_comb begin
    sel    = '0;
    found  = 1'b0;
    rr_idx = 0;
    for (int unsigned i = 0; i < N; i++) begin
      rr_idx = (32'(start_q) >= i) ? 32'(start_q) - i : 32'(start_q) + N - i;
      if (!found && |(pending_q & (N'(1) << rr_idx))) begin
        sel   = IDX_W'(rr_idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    start_d = start_q;
    if (load) begin
      start_d = (sel == '0) ? IDX_W'(N - 1) : sel - IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= IDX_W'(N - 1);
    end else begin
      start_q <= start_d;
    end
  end
`else
  // Fixed priority: the last match in ascending order is the highest index.
  always_comb begin
    sel = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (pending_q[k]) begin
        sel = IDX_W'(k);
      end
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable && (pending_q != '0)) begin
          load    = 1'b1;
          state_d = StHold;
        end
      end
      StHold: begin
        if (out_ready) begin
          if (enable && (pending_q != '0)) begin
            load = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    clr       = load ? (N'(1) << sel) : '0;
    // New requests are OR-ed in after the clear, so a same-cycle set wins.
    pending_d = (pending_q & ~clr) | (enable ? req : '0);
    // The bit being granted this cycle is not a duplicate.
    overflow_d = enable && ((req & pending_q & ~clr) != '0);
    out_idx_d  = load ? sel : out_idx_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pending_q  <= '0;
      out_idx_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      out_idx_q  <= out_idx_d;
      overflow_q <= overflow_d;
    end
  end

  assign out_valid = (state_q == StHold);
  assign out_idx   = out_idx_q;
  assign pending   = pending_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_prio_enc_queue.sv
// Directed bench for prio_enc_queue (N=8, IDX_W=3). Inputs change 1ns after
// a rising edge; outputs are sampled at that point too.
module tb_prio_enc_queue;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] req = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [2:0] out_idx;
  logic [7:0] pending;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  prio_enc_queue #(.N(8), .IDX_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .req       (req),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .pending   (pending),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 8'hFF; enable = 1'b1; out_ready = 1'b0;
    repeat (3) step();
    checks++;
    if ({out_valid, pending, overflow} !== 10'b0) begin
      errors++;
      $display("FAIL reset_hold got v=%b p=%h o=%b want 0 00 0", out_valid, pending, overflow);
    end
    rst_n = 1'b1; req = 8'h00;
    step();
    checks++;
    if ({out_valid, pending, overflow, out_idx} !== 13'b0) begin
      errors++;
      $display("FAIL reset_release got v=%b p=%h o=%b i=%0d want all 0",
               out_valid, pending, overflow, out_idx);
    end
  endtask

  task automatic test_drain();
    logic [2:0] exp_idx [4];
    exp_idx = '{3'd6, 3'd5, 3'd4, 3'd3};
    enable = 1'b1; out_ready = 1'b1; req = 8'h78;
    step();
    req = 8'h00;
    checks++;
    if (pending !== 8'h78 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_latch got p=%h v=%b want 78 0", pending, out_valid);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_idx !== exp_idx[i]) begin
        errors++;
        $display("FAIL drain_idx%0d got v=%b i=%0d want 1 %0d", i, out_valid, out_idx, exp_idx[i]);
      end
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || pending !== 8'h00) begin
      errors++;
      $display("FAIL drain_end got v=%b p=%h want 0 00", out_valid, pending);
    end
  endtask

  task automatic test_backpressure();
    enable = 1'b1; out_ready = 1'b0; req = 8'h40;
    step();
    req = 8'h00;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 3'd6) begin
      errors++;
      $display("FAIL bp_hold got v=%b i=%0d want 1 6", out_valid, out_idx);
    end
    req = 8'h80;
    step();
    req = 8'h00;
    step();
    checks++;
    if (pending !== 8'h80 || out_idx !== 3'd6 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_stable got p=%h i=%0d v=%b want 80 6 1", pending, out_idx, out_valid);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 3'd7 || pending !== 8'h00) begin
      errors++;
      $display("FAIL bp_next got v=%b i=%0d p=%h want 1 7 00", out_valid, out_idx, pending);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_end got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_overflow();
    enable = 1'b1; out_ready = 1'b0; req = 8'h40;
    step();
    req = 8'h00;
    step();
    req = 8'h04;
    step();
    checks++;
    if (overflow !== 1'b0 || pending !== 8'h04) begin
      errors++;
      $display("FAIL ovf_first got o=%b p=%h want 0 04", overflow, pending);
    end
    step();
    req = 8'h00;
    checks++;
    if (overflow !== 1'b1 || pending !== 8'h04 || out_idx !== 3'd6) begin
      errors++;
      $display("FAIL ovf_pulse got o=%b p=%h i=%0d want 1 04 6", overflow, pending, out_idx);
    end
    step();
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear got o=%b want 0", overflow);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 3'd2) begin
      errors++;
      $display("FAIL ovf_drain got v=%b i=%0d want 1 2", out_valid, out_idx);
    end
    step();
  endtask

  // Grant and re-request of the same bit in one cycle: set wins, no overflow.
  task automatic test_collision();
    enable = 1'b1; out_ready = 1'b0; req = 8'h10;
    step();
    step();
    req = 8'h00;
    checks++;
    if (out_idx !== 3'd4 || pending !== 8'h10 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL coll_set got i=%0d p=%h o=%b want 4 10 0", out_idx, pending, overflow);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 3'd4 || pending !== 8'h00) begin
      errors++;
      $display("FAIL coll_regrant got v=%b i=%0d p=%h want 1 4 00", out_valid, out_idx, pending);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL coll_end got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_enable_gate();
    enable = 1'b0; out_ready = 1'b0; req = 8'h02;
    step();
    req = 8'h00;
    step();
    checks++;
    if (pending !== 8'h00 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL en_block got p=%h v=%b want 00 0", pending, out_valid);
    end
    enable = 1'b1; req = 8'h01;
    step();
    req = 8'h00;
    step();
    enable = 1'b0; req = 8'h02;
    step();
    req = 8'h00;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 3'd0 || pending !== 8'h00) begin
      errors++;
      $display("FAIL en_hold got v=%b i=%0d p=%h want 1 0 00", out_valid, out_idx, pending);
    end
    enable = 1'b1; req = 8'h02;
    step();
    req = 8'h00; enable = 1'b0; out_ready = 1'b1;
    step();
    step();
    checks++;
    if (out_valid !== 1'b0 || pending !== 8'h02) begin
      errors++;
      $display("FAIL en_noload got v=%b p=%h want 0 02", out_valid, pending);
    end
    enable = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 3'd1) begin
      errors++;
      $display("FAIL en_resume got v=%b i=%0d want 1 1", out_valid, out_idx);
    end
    step();
  endtask

  task automatic test_priority_order();
    logic [2:0] first;
    logic [2:0] second;
`ifdef PRIENC_RR_EN
    first = 3'd0; second = 3'd7;
`else
    first = 3'd7; second = 3'd0;
`endif
    enable = 1'b1; out_ready = 1'b1; req = 8'h80;
    step();
    req = 8'h00;
    step();
    step();
    req = 8'h81;
    step();
    req = 8'h00;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_idx !== first) begin
      errors++;
      $display("FAIL prio_first got v=%b i=%0d want 1 %0d", out_valid, out_idx, first);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_idx !== second) begin
      errors++;
      $display("FAIL prio_second got v=%b i=%0d want 1 %0d", out_valid, out_idx, second);
    end
    step();
  endtask

  task automatic test_mid_reset();
    enable = 1'b1; out_ready = 1'b0; req = 8'h81;
    step();
    req = 8'h00;
    step();
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || pending !== 8'h00 || out_idx !== 3'd0) begin
      errors++;
      $display("FAIL mrst_async got v=%b p=%h i=%0d want 0 00 0", out_valid, pending, out_idx);
    end
    step();
    rst_n = 1'b1; out_ready = 1'b1; req = 8'h81;
    step();
    req = 8'h00;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 3'd7) begin
      errors++;
      $display("FAIL mrst_ptr got v=%b i=%0d want 1 7", out_valid, out_idx);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 3'd0) begin
      errors++;
      $display("FAIL mrst_next got v=%b i=%0d want 1 0", out_valid, out_idx);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_drain();
    test_backpressure();
    test_overflow();
    test_collision();
    test_enable_gate();
    test_priority_order();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
